// File: rtl/cache_pkg.sv
// Shared types, op/command encodings and the MESI / tree-PLRU next-state helpers
// for the 8-way L2 tag/state store.
package cache_pkg;

  localparam int WAYS = 8;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2
  } snoop_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WRITE_TAG = 3'd1;
  localparam logic [2:0] OP_TOUCH_LRU = 3'd2;
  localparam logic [2:0] OP_SET_MESI  = 3'd3;
  localparam logic [2:0] OP_CLEAR_ALL = 3'd4;

  localparam logic [3:0] CMD_READ      = 4'd0;
  localparam logic [3:0] CMD_WRITE     = 4'd1;
  localparam logic [3:0] CMD_IREAD     = 4'd2;
  localparam logic [3:0] CMD_SNP_INV   = 4'd3;
  localparam logic [3:0] CMD_SNP_READ  = 4'd4;
  localparam logic [3:0] CMD_SNP_WRITE = 4'd5;
  localparam logic [3:0] CMD_SNP_RWIM  = 4'd6;

  // MESI transition for one line given the trace command and the bus snoop result.
  function automatic mesi_t mesi_next(input mesi_t s, input logic [3:0] cmd, input logic [1:0] snp);
    mesi_t n;
    n = s;
    case (cmd)
      CMD_READ, CMD_IREAD: begin
        if (s == MESI_I) begin
          if (snp == SNP_NOHIT)                      n = MESI_E;
          else if (snp == SNP_HIT || snp == SNP_HITM) n = MESI_S;
        end
      end
      CMD_WRITE:    n = MESI_M;
      CMD_SNP_INV:  if (s == MESI_S) n = MESI_I;
      CMD_SNP_READ: if (s == MESI_E || s == MESI_M) n = MESI_S;
      CMD_SNP_RWIM: n = MESI_I;
      default:      n = s;
    endcase
    return n;
  endfunction

  // Tree layout: bit0 root, bits1-2 level-1 nodes (ways 0-3 / 4-7),
  // bits3-6 leaves (pairs 0-1, 2-3, 4-5, 6-7). Touch points every node on the path away.
  function automatic logic [6:0] plru_update(input logic [6:0] st, input logic [2:0] way);
    logic [6:0] n;
    n = st;
    n[0]                     = ~way[2];
    n[1 + int'(way[2])]      = ~way[1];
    n[3 + int'(way[2:1])]    = ~way[0];
    return n;
  endfunction

  // Follow the node bits from the root: 0 = left (lower ways), 1 = right.
  function automatic logic [2:0] plru_victim(input logic [6:0] st);
    logic [2:0] v;
    v[2] = st[0];
    v[1] = st[1 + int'(v[2])];
    v[0] = st[3 + int'(v[2:1])];
    return v;
  endfunction

endpackage

// File: rtl/cache_module_plru_tree8.sv
// 7-bit tree pseudo-LRU for one 8-way set: next state for a touched way, and current victim.
module plru_tree8
  import cache_pkg::*;
(
  input  logic [6:0] state,
  input  logic [2:0] way,
  output logic [6:0] next_state,
  output logic [2:0] victim
);

  assign next_state = plru_update(state, way);
  assign victim     = plru_victim(state);

endmodule

// File: rtl/cache_module.sv
// Tag / MESI / PLRU store for an 8-way set-associative L2 slice. One maintenance
// op per cycle; all query outputs are combinational from the stored state of req_index.
module cache_module
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 12,
  parameter int ADDR_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [2:0]            req_way,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [3:0]            req_cmd,
  input  logic [1:0]            req_snoop,
  input  logic [ADDR_BITS-1:0]  snoop_addr,
  output logic [1:0]            snoop_result,
  output logic                  empty_found,
  output logic [2:0]            empty_way,
  output logic [2:0]            victim_way,
  output logic [1:0]            rd_mesi,
  output logic [TAG_BITS-1:0]   rd_tag
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [WAYS-1:0][TAG_BITS-1:0] tag_q  [SETS];
  logic [WAYS-1:0][1:0]          mesi_q [SETS];
  logic [6:0]                    plru_q [SETS];

  logic [6:0] plru_nxt;
  mesi_t      mesi_nxt;

  // Only the low two address bits carry the snoop response encoding.
  logic unused_snoop_hi;
  assign unused_snoop_hi = ^snoop_addr[ADDR_BITS-1:2];

  plru_tree8 u_plru (
    .state      (plru_q[req_index]),
    .way        (req_way),
    .next_state (plru_nxt),
    .victim     (victim_way)
  );

  assign mesi_nxt = mesi_next(mesi_t'(mesi_q[req_index][req_way]), req_cmd, req_snoop);

  // Reset / CLEAR_ALL invalidate everything; other ops update one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        tag_q[s]  <= '0;
        mesi_q[s] <= '0;
        plru_q[s] <= '0;
      end
    end else if (req_valid) begin
      case (req_op)
        OP_WRITE_TAG: tag_q[req_index][req_way]  <= req_tag;
        OP_TOUCH_LRU: plru_q[req_index]          <= plru_nxt;
        OP_SET_MESI:  mesi_q[req_index][req_way] <= mesi_nxt;
        OP_CLEAR_ALL: begin
          for (int s = 0; s < SETS; s++) begin
            tag_q[s]  <= '0;
            mesi_q[s] <= '0;
            plru_q[s] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Lowest-numbered Invalid way; scanning downward lets the lowest hit win.
  always_comb begin
    empty_found = 1'b0;
    empty_way   = 3'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_q[req_index][w] == MESI_I) begin
        empty_found = 1'b1;
        empty_way   = 3'(w);
      end
    end
  end

  // Bus snoop response decode from the low address bits.
  always_comb begin
    if (snoop_addr[1])      snoop_result = SNP_NOHIT;
    else if (snoop_addr[0]) snoop_result = SNP_HITM;
    else                    snoop_result = SNP_HIT;
  end

  assign rd_mesi = mesi_q[req_index][req_way];
  assign rd_tag  = tag_q[req_index][req_way];

endmodule

// File: tb/tb_cache_module.sv
// Directed bench for cache_module with an expectation queue popped at each sample point.
module tb_cache_module;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [5:0]  req_index;
  logic [2:0]  req_way;
  logic [11:0] req_tag;
  logic [3:0]  req_cmd;
  logic [1:0]  req_snoop;
  logic [31:0] snoop_addr;
  logic [1:0]  snoop_result;
  logic        empty_found;
  logic [2:0]  empty_way;
  logic [2:0]  victim_way;
  logic [1:0]  rd_mesi;
  logic [11:0] rd_tag;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  cache_module dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_index(req_index), .req_way(req_way), .req_tag(req_tag), .req_cmd(req_cmd),
    .req_snoop(req_snoop), .snoop_addr(snoop_addr), .snoop_result(snoop_result),
    .empty_found(empty_found), .empty_way(empty_way), .victim_way(victim_way),
    .rd_mesi(rd_mesi), .rd_tag(rd_tag)
  );

  task automatic expect_v(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] obs);
    logic [31:0] exp;
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", nm, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        nerr++;
        $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
    end
  endtask

  task automatic op(input logic [2:0] o, input logic [5:0] idx, input logic [2:0] w,
                    input logic [11:0] t, input logic [3:0] c, input logic [1:0] s);
    req_op = o; req_index = idx; req_way = w; req_tag = t; req_cmd = c; req_snoop = s;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = OP_NOP;
  endtask

  task automatic sel(input logic [5:0] idx, input logic [2:0] w);
    req_index = idx; req_way = w;
    #1;
  endtask

  initial begin
    logic [31:0] addrs [4];
    logic [1:0]  snp_exp [4];
    rst_n = 1'b0; req_valid = 1'b0; req_op = OP_NOP; req_index = '0; req_way = '0;
    req_tag = '0; req_cmd = '0; req_snoop = '0; snoop_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state of set 0
    sel(0, 0);
    expect_v(1); chk("rst_empty_found", empty_found);
    expect_v(0); chk("rst_empty_way", empty_way);
    expect_v(0); chk("rst_victim", victim_way);
    for (int w = 0; w < 8; w++) begin
      sel(0, 3'(w));
      expect_v(MESI_I); chk($sformatf("rst_mesi_w%0d", w), rd_mesi);
    end
    expect_v(0); chk("rst_tag_w7", rd_tag);

    // Fill set 0 way by way: tag, touch, write -> M
    snoop_addr = 32'h0;
    #1;
    expect_v(SNP_HIT); chk("fill_snoop", snoop_result);
    for (int w = 0; w < 8; w++) begin
      op(OP_WRITE_TAG, 0, 3'(w), 12'(w), 0, SNP_HIT);
      op(OP_TOUCH_LRU, 0, 3'(w), 0, 0, SNP_HIT);
      op(OP_SET_MESI,  0, 3'(w), 0, CMD_WRITE, SNP_HIT);
      if (w == 6) begin
        for (int k = 0; k < 7; k++) begin
          sel(0, 3'(k));
          expect_v(MESI_M); chk($sformatf("fill_mesi_w%0d", k), rd_mesi);
        end
        expect_v(1); chk("fill7_empty_found", empty_found);
        expect_v(7); chk("fill7_empty_way", empty_way);
      end
    end
    sel(0, 7);
    expect_v(0);      chk("full_empty_found", empty_found);
    expect_v(0);      chk("full_empty_way", empty_way);
    expect_v(7);      chk("full_tag_w7", rd_tag);
    expect_v(MESI_M); chk("full_mesi_w7", rd_mesi);
    expect_v(0);      chk("plru_after_0to7", victim_way);
    op(OP_TOUCH_LRU, 0, 0, 0, 0, SNP_HIT);
    expect_v(4);      chk("plru_after_touch0", victim_way);

    // Write visible only after the edge; old value during the issuing cycle
    req_op = OP_WRITE_TAG; req_index = 0; req_way = 2; req_tag = 12'hABC; req_valid = 1'b1;
    #1;
    expect_v(2); chk("same_cycle_old_tag", rd_tag);
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = OP_NOP;
    expect_v(12'hABC); chk("new_tag", rd_tag);
    op(3'd5, 0, 2, 12'h111, CMD_WRITE, SNP_HIT);
    expect_v(12'hABC); chk("op5_nop_tag", rd_tag);
    op(OP_WRITE_TAG, 0, 2, 12'h222, 0, SNP_HIT);
    op(OP_NOP, 0, 2, 12'h333, 0, SNP_HIT);
    expect_v(12'h222); chk("op0_nop_tag", rd_tag);

    // MESI walk on set 2 way 3
    op(OP_SET_MESI, 2, 3, 0, CMD_READ, SNP_NOHIT);
    expect_v(MESI_E); chk("I_rd_nohit_E", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_SNP_WRITE, SNP_HIT);
    expect_v(MESI_E); chk("E_snpwr_E", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_SNP_READ, SNP_HIT);
    expect_v(MESI_S); chk("E_snprd_S", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_SNP_INV, SNP_HIT);
    expect_v(MESI_I); chk("S_snpinv_I", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_IREAD, SNP_HITM);
    expect_v(MESI_S); chk("I_iread_hitm_S", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_READ, SNP_NOHIT);
    expect_v(MESI_S); chk("S_rd_stays_S", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_WRITE, SNP_HIT);
    expect_v(MESI_M); chk("S_wr_M", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_SNP_INV, SNP_HIT);
    expect_v(MESI_M); chk("M_snpinv_M", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_SNP_RWIM, SNP_HIT);
    expect_v(MESI_I); chk("M_rwim_I", rd_mesi);
    op(OP_SET_MESI, 2, 3, 0, CMD_SNP_READ, SNP_HIT);
    expect_v(MESI_I); chk("I_snprd_I", rd_mesi);

    // Snoop decode
    addrs   = '{32'hDEADBE00, 32'hDEADBE01, 32'hDEADBE02, 32'hDEADBE03};
    snp_exp = '{SNP_HIT, SNP_HITM, SNP_NOHIT, SNP_NOHIT};
    for (int i = 0; i < 4; i++) begin
      snoop_addr = addrs[i];
      #1;
      expect_v(32'(snp_exp[i])); chk($sformatf("snoop_%0d", i), snoop_result);
    end

    // CLEAR_ALL wipes every set
    op(OP_SET_MESI, 5, 0, 0, CMD_WRITE, SNP_HIT);
    op(OP_TOUCH_LRU, 5, 0, 0, 0, SNP_HIT);
    sel(5, 0);
    expect_v(1); chk("set5_empty_way_pre", empty_way);
    op(OP_CLEAR_ALL, 0, 0, 0, 0, SNP_HIT);
    sel(0, 7);
    expect_v(1); chk("clr_empty_found", empty_found);
    expect_v(0); chk("clr_empty_way", empty_way);
    expect_v(0); chk("clr_victim", victim_way);
    expect_v(0); chk("clr_tag_w7", rd_tag);
    expect_v(MESI_I); chk("clr_mesi_w7", rd_mesi);
    sel(5, 0);
    expect_v(0); chk("clr_set5_empty_way", empty_way);
    expect_v(0); chk("clr_set5_victim", victim_way);

    // Async reset in the middle of an op
    op(OP_WRITE_TAG, 1, 1, 12'h5A5, 0, SNP_HIT);
    op(OP_SET_MESI, 1, 1, 0, CMD_WRITE, SNP_HIT);
    req_op = OP_WRITE_TAG; req_tag = 12'hFFF; req_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    expect_v(0);      chk("arst_tag", rd_tag);
    expect_v(MESI_I); chk("arst_mesi", rd_mesi);
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = OP_NOP; rst_n = 1'b1;
    #1;
    expect_v(0); chk("arst_hold_tag", rd_tag);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
